wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage MIPS pipeline. Sits between the memory stage and the register file.
- Takes one retiring instruction per handshake from the memory stage. For loads, waits for the data-bus response, then aligns and extends the load data.
- Drives the register-file write port (wa3/wd3/write_enable) and publishes forwarding/hazard information to decode.

Parameters:
RESET_PC, 32'hbfc0_0000, value of commit_pc after reset.

Ports:
clk  in  1  clock; all state updates on posedge.
resetn  in  1  asynchronous, active-low reset.
m_valid  in  1  memory stage offers an instruction.
m_ready  out  1  wb_stage accepts this cycle.
m_pc  in  32  instruction PC.
m_dst  in  5  destination register (creg_addr_t).
m_wen  in  1  instruction writes a register.
m_is_load  in  1  result comes from data bus.
m_load_size  in  2  load_size_t: 0 byte, 1 half, 2 word.
m_load_unsigned  in  1  zero-extend (lbu/lhu).
m_addr_lo  in  2  low bits of load address.
m_alu_result  in  32  result for non-loads.
dresp_valid  in  1  data-bus read response.
dresp_data  in  32  raw aligned word from data bus.
wa3  out  5  regfile write address.
wd3  out  32  regfile write data.
write_enable  out  1  regfile write strobe.
fwd_valid  out  1  slot holds a pending register write.
fwd_ready  out  1  fwd_data is final this cycle.
fwd_addr  out  5  destination of pending write.
fwd_data  out  32  value of pending write.
commit_valid  out  1  one instruction retires this cycle.
commit_pc  out  32  PC of last retired instruction, registered.

Behaviour:
- Reset (async, resetn=0):
  - state=EMPTY; slot cleared.
  - write_enable=0, commit_valid=0, fwd_valid=0.
  - wa3=0, wd3=0, commit_pc=RESET_PC.
- States: EMPTY, READY (non-load held), WAIT_DATA (load held, no response yet).
- Accept: transfer when m_valid && m_ready. Slot fields are registered. Next state is READY if !m_is_load, otherwise WAIT_DATA.
- Commit is combinational in the cycle it occurs:
  - READY: commits unconditionally.
  - WAIT_DATA: commits only when dresp_valid=1.
- On commit:
  - commit_valid=1.
  - write_enable = slot.wen && slot.dst!=0.
  - wa3 = slot.dst.
  - wd3 = alu_result, or extended load data.
  - commit_pc is registered at the same edge.
- m_ready = (state==EMPTY) || commit_this_cycle. This gives back-to-back full throughput with a 1-cycle stage latency for non-loads.
- After commit, with no new accept, state returns to EMPTY.
- dresp_valid while EMPTY or READY is ignored. It is never buffered and never attributed to a later load.
- A response in the same cycle as a load's accept is ignored. Only responses seen in WAIT_DATA count.
- WAIT_DATA holds indefinitely. There is no timeout, and m_ready=0 throughout.
- Load extension, little-endian:
  - byte: lane = addr_lo.
  - half: lane = addr_lo[1].
  - sign- or zero-extended per m_load_unsigned.
  - word: passthrough.
  - Misalignment is not checked; it is trapped upstream. load_size=3 is treated as word.
- Forwarding:
  - fwd_valid = state!=EMPTY && slot.wen && slot.dst!=0.
  - fwd_addr = slot.dst.
  - fwd_ready = (state==READY) || (state==WAIT_DATA && dresp_valid).
  - fwd_data equals wd3 whenever fwd_ready.
  - Decode stalls on fwd_valid && !fwd_ready.
- Writes to $0 are never issued; write_enable stays 0.
- The register file reads its old value in the write cycle. Decode must use fwd_* for same-cycle bypass.
- There is no flush input: instructions reaching wb_stage are architecturally committed.
- Reset mid-WAIT_DATA drops the load. A stale dresp_valid after reset lands in EMPTY and is ignored.

Decomposition:
- Shared package (common.svh): word_t, creg_addr_t (moved out of the register file into the package), load_size_t enum, wb_state_t enum, and packed struct wb_slot_t {pc, dst, wen, is_load, load_size, load_unsigned, addr_lo, alu_result}.
- Sub-module load_extend: combinational; inputs raw word, size, unsigned, addr_lo; output word_t.

Test Plan:
- Reset then release: state EMPTY, m_ready=1, write_enable=0, commit_pc=32'hbfc0_0000.
- Three back-to-back non-loads (dst 1,2,3; results 11,22,33), m_valid held high:
  - m_ready stays 1.
  - write_enable pulses on three consecutive cycles with wa3=1,2,3 and wd3=11,22,33.
- lb dst=4, addr_lo=3, response arrives 3 cycles later with dresp_data=32'h80_00_00_00:
  - m_ready=0 and fwd_valid=1/fwd_ready=0 while waiting.
  - On response: wd3=32'hffff_ff80 and write_enable=1.
  - Repeat as lbu: wd3=32'h0000_0080.
- lh addr_lo=2 with dresp_data=32'h1234_5678 -> wd3=32'h0000_1234. lhu addr_lo=0 with data 32'h0000_9abc -> wd3=32'h0000_9abc.
- Instruction with dst=0, wen=1 -> commit_valid=1, write_enable=0, fwd_valid=0.
- Stray and reset cases:
  - Stray dresp_valid while EMPTY, then a non-load is accepted -> committed data is alu_result.
  - resetn asserted during WAIT_DATA, then dresp_valid after release -> no write, state EMPTY.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared types for the writeback stage (words, register addresses, load sizes, FSM states, slot record)
package wb_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;

    // Encoding 3 is reserved and behaves as a full word load
    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_RSVD = 2'd3
    } load_size_t;

    typedef enum logic [1:0] {
        WB_EMPTY     = 2'd0,
        WB_READY     = 2'd1,
        WB_WAIT_DATA = 2'd2
    } wb_state_t;

    typedef struct packed {
        word_t      pc;
        creg_addr_t dst;
        logic       wen;
        logic       is_load;
        load_size_t load_size;
        logic       load_unsigned;
        logic [1:0] addr_lo;
        word_t      alu_result;
    } wb_slot_t;

endpackage

// File: rtl/wb_stage_load_extend.sv
// wb_stage_load_extend: little-endian lane select and sign/zero extension of raw load data
//   raw_i      raw aligned word from the data bus
//   size_i     byte / half / word (reserved encoding acts as word)
//   unsigned_i zero-extend instead of sign-extend
//   addr_lo_i  low two bits of the load address, selects the lane
//   data_o     extended value for the register file
module wb_stage_load_extend
    import wb_stage_pkg::*;
(
    input  word_t      raw_i,
    input  load_size_t size_i,
    input  logic       unsigned_i,
    input  logic [1:0] addr_lo_i,
    output word_t      data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = raw_i[{addr_lo_i, 3'b000} +: 8];
        half_lane = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        data_o    = (size_i == LS_BYTE) ? {{24{~unsigned_i & byte_lane[7]}}, byte_lane} :
                    (size_i == LS_HALF) ? {{16{~unsigned_i & half_lane[15]}}, half_lane} :
                    raw_i;
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage; holds one retiring instruction, waits for load data, drives regfile write and forwarding
//   clk, resetn                         clock, async active-low reset
//   m_valid/m_ready + m_* fields        handshake and instruction record from the memory stage
//   dresp_valid, dresp_data             data-bus read response (only meaningful while a load waits)
//   wa3, wd3, write_enable              register-file write port
//   fwd_valid/ready/addr/data           pending-write bypass information for decode
//   commit_valid, commit_pc             retire strobe and PC of the last retired instruction
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter word_t RESET_PC = 32'hbfc0_0000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       m_valid,
    output logic       m_ready,
    input  word_t      m_pc,
    input  creg_addr_t m_dst,
    input  logic       m_wen,
    input  logic       m_is_load,
    input  load_size_t m_load_size,
    input  logic       m_load_unsigned,
    input  logic [1:0] m_addr_lo,
    input  word_t      m_alu_result,
    input  logic       dresp_valid,
    input  word_t      dresp_data,
    output creg_addr_t wa3,
    output word_t      wd3,
    output logic       write_enable,
    output logic       fwd_valid,
    output logic       fwd_ready,
    output creg_addr_t fwd_addr,
    output word_t      fwd_data,
    output logic       commit_valid,
    output word_t      commit_pc
);

    wb_state_t state_q, state_d;
    wb_slot_t  slot_q, slot_d;
    word_t     commit_pc_q, commit_pc_d;
    word_t     load_data;
    word_t     result;
    logic      commit;
    logic      accept;
    logic      writes_reg;

    wb_stage_load_extend u_load_extend (
        .raw_i      (dresp_data),
        .size_i     (slot_q.load_size),
        .unsigned_i (slot_q.load_unsigned),
        .addr_lo_i  (slot_q.addr_lo),
        .data_o     (load_data)
    );

    // A response only counts once the load already sits in WAIT_DATA; in any other state it is dropped
    always_comb begin
        commit      = (state_q == WB_READY) || (state_q == WB_WAIT_DATA && dresp_valid);
        m_ready     = (state_q == WB_EMPTY) || commit;
        accept      = m_valid && m_ready;
        writes_reg  = slot_q.wen && (slot_q.dst != '0);
        result      = slot_q.is_load ? load_data : slot_q.alu_result;
        state_d     = accept ? (m_is_load ? WB_WAIT_DATA : WB_READY) :
                      commit ? WB_EMPTY : state_q;
        slot_d      = accept ? '{pc: m_pc, dst: m_dst, wen: m_wen, is_load: m_is_load,
                                 load_size: m_load_size, load_unsigned: m_load_unsigned,
                                 addr_lo: m_addr_lo, alu_result: m_alu_result} : slot_q;
        commit_pc_d = commit ? slot_q.pc : commit_pc_q;
    end

    always_comb begin
        commit_valid = commit;
        write_enable = commit && writes_reg;
        wa3          = commit ? slot_q.dst : '0;
        wd3          = commit ? result : '0;
        fwd_valid    = (state_q != WB_EMPTY) && writes_reg;
        fwd_ready    = commit;
        fwd_addr     = slot_q.dst;
        fwd_data     = result;
        commit_pc    = commit_pc_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= WB_EMPTY;
            slot_q      <= '0;
            commit_pc_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            commit_pc_q <= commit_pc_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       m_valid;
    logic       m_ready;
    word_t      m_pc;
    creg_addr_t m_dst;
    logic       m_wen;
    logic       m_is_load;
    load_size_t m_load_size;
    logic       m_load_unsigned;
    logic [1:0] m_addr_lo;
    word_t      m_alu_result;
    logic       dresp_valid;
    word_t      dresp_data;
    creg_addr_t wa3;
    word_t      wd3;
    logic       write_enable;
    logic       fwd_valid;
    logic       fwd_ready;
    creg_addr_t fwd_addr;
    word_t      fwd_data;
    logic       commit_valid;
    word_t      commit_pc;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        we;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_stage #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_pc            (m_pc),
        .m_dst           (m_dst),
        .m_wen           (m_wen),
        .m_is_load       (m_is_load),
        .m_load_size     (m_load_size),
        .m_load_unsigned (m_load_unsigned),
        .m_addr_lo       (m_addr_lo),
        .m_alu_result    (m_alu_result),
        .dresp_valid     (dresp_valid),
        .dresp_data      (dresp_data),
        .wa3             (wa3),
        .wd3             (wd3),
        .write_enable    (write_enable),
        .fwd_valid       (fwd_valid),
        .fwd_ready       (fwd_ready),
        .fwd_addr        (fwd_addr),
        .fwd_data        (fwd_data),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] dst, input logic wen,
                         input logic ld, input load_size_t sz, input logic uns,
                         input logic [1:0] alo, input logic [31:0] res, input logic [31:0] exp_d);
        exp_t e;
        m_valid = 1'b1; m_pc = pc; m_dst = dst; m_wen = wen; m_is_load = ld;
        m_load_size = sz; m_load_unsigned = uns; m_addr_lo = alo; m_alu_result = res;
        e.a = dst; e.d = exp_d; e.we = wen && (dst != 5'd0); e.pc = pc;
        q.push_back(e);
    endtask

    task automatic idle();
        m_valid = 1'b0;
    endtask

    // Checks combinational outputs for the current cycle's inputs, then crosses one clock edge
    task automatic cyc(input string tag, input logic exp_ready, input logic exp_commit);
        exp_t e;
        logic popped;
        popped = 1'b0;
        #1;
        chk({tag, ".m_ready"}, {31'd0, m_ready}, {31'd0, exp_ready});
        chk({tag, ".commit_valid"}, {31'd0, commit_valid}, {31'd0, exp_commit});
        if (commit_valid && q.size() > 0) begin
            e = q.pop_front();
            popped = 1'b1;
            chk({tag, ".wa3"}, {27'd0, wa3}, {27'd0, e.a});
            chk({tag, ".wd3"}, wd3, e.d);
            chk({tag, ".write_enable"}, {31'd0, write_enable}, {31'd0, e.we});
            chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, e.we});
            chk({tag, ".fwd_ready"}, {31'd0, fwd_ready}, 32'd1);
            chk({tag, ".fwd_data"}, fwd_data, e.d);
        end else if (!commit_valid) begin
            chk({tag, ".write_enable_idle"}, {31'd0, write_enable}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (popped) chk({tag, ".commit_pc"}, commit_pc, e.pc);
        @(negedge clk);
    endtask

    task automatic wait_chk(input string tag, input logic [4:0] dst);
        #1;
        chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, 32'd1);
        chk({tag, ".fwd_ready"}, {31'd0, fwd_ready}, 32'd0);
        chk({tag, ".fwd_addr"}, {27'd0, fwd_addr}, {27'd0, dst});
        cyc(tag, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; m_valid = 1'b0; m_pc = '0; m_dst = '0; m_wen = 1'b0; m_is_load = 1'b0;
        m_load_size = LS_WORD; m_load_unsigned = 1'b0; m_addr_lo = 2'd0; m_alu_result = '0;
        dresp_valid = 1'b0; dresp_data = '0;
        repeat (3) @(negedge clk);
        chk("rst.commit_pc", commit_pc, 32'hbfc0_0000);
        chk("rst.wa3", {27'd0, wa3}, 32'd0);
        chk("rst.wd3", wd3, 32'd0);
        chk("rst.fwd_valid", {31'd0, fwd_valid}, 32'd0);
        resetn = 1'b1;
        cyc("rel", 1'b1, 1'b0);
        chk("rel.commit_pc", commit_pc, 32'hbfc0_0000);

        issue(32'h100, 5'd1, 1'b1, 1'b0, LS_WORD, 1'b0, 2'd0, 32'd11, 32'd11);
        cyc("nl1", 1'b1, 1'b0);
        issue(32'h104, 5'd2, 1'b1, 1'b0, LS_WORD, 1'b0, 2'd0, 32'd22, 32'd22);
        cyc("nl2", 1'b1, 1'b1);
        issue(32'h108, 5'd3, 1'b1, 1'b0, LS_WORD, 1'b0, 2'd0, 32'd33, 32'd33);
        cyc("nl3", 1'b1, 1'b1);
        idle();
        cyc("nl_drain", 1'b1, 1'b1);
        cyc("nl_idle", 1'b1, 1'b0);

        issue(32'h200, 5'd4, 1'b1, 1'b1, LS_BYTE, 1'b0, 2'd3, 32'hdead_beef, 32'hffff_ff80);
        cyc("lb_acc", 1'b1, 1'b0);
        idle();
        wait_chk("lb_w1", 5'd4);
        wait_chk("lb_w2", 5'd4);
        dresp_valid = 1'b1; dresp_data = 32'h8000_0000;
        cyc("lb_resp", 1'b1, 1'b1);
        dresp_valid = 1'b0;

        issue(32'h204, 5'd4, 1'b1, 1'b1, LS_BYTE, 1'b1, 2'd3, 32'hdead_beef, 32'h0000_0080);
        dresp_valid = 1'b1; dresp_data = 32'h7f00_0000;
        cyc("lbu_acc", 1'b1, 1'b0);
        idle(); dresp_valid = 1'b0;
        wait_chk("lbu_w1", 5'd4);
        wait_chk("lbu_w2", 5'd4);
        dresp_valid = 1'b1; dresp_data = 32'h8000_0000;
        cyc("lbu_resp", 1'b1, 1'b1);
        dresp_valid = 1'b0;

        issue(32'h300, 5'd7, 1'b1, 1'b1, LS_HALF, 1'b0, 2'd2, 32'h0, 32'h0000_1234);
        cyc("lh_acc", 1'b1, 1'b0);
        idle();
        dresp_valid = 1'b1; dresp_data = 32'h1234_5678;
        cyc("lh_resp", 1'b1, 1'b1);
        dresp_valid = 1'b0;
        issue(32'h304, 5'd8, 1'b1, 1'b1, LS_HALF, 1'b1, 2'd0, 32'h0, 32'h0000_9abc);
        cyc("lhu_acc", 1'b1, 1'b0);
        idle();
        dresp_valid = 1'b1; dresp_data = 32'h0000_9abc;
        cyc("lhu_resp", 1'b1, 1'b1);
        dresp_valid = 1'b0;
        issue(32'h308, 5'd9, 1'b1, 1'b1, LS_HALF, 1'b0, 2'd0, 32'h0, 32'hffff_9abc);
        cyc("lhs_acc", 1'b1, 1'b0);
        idle();
        dresp_valid = 1'b1; dresp_data = 32'h0000_9abc;
        cyc("lhs_resp", 1'b1, 1'b1);
        dresp_valid = 1'b0;
        issue(32'h30c, 5'd10, 1'b1, 1'b1, LS_RSVD, 1'b0, 2'd0, 32'h0, 32'hcafe_f00d);
        cyc("lw3_acc", 1'b1, 1'b0);
        idle();
        dresp_valid = 1'b1; dresp_data = 32'hcafe_f00d;
        cyc("lw3_resp", 1'b1, 1'b1);
        dresp_valid = 1'b0;

        issue(32'h400, 5'd0, 1'b1, 1'b0, LS_WORD, 1'b0, 2'd0, 32'd77, 32'd77);
        cyc("z_acc", 1'b1, 1'b0);
        idle();
        #1;
        chk("z.fwd_valid", {31'd0, fwd_valid}, 32'd0);
        cyc("z_commit", 1'b1, 1'b1);

        dresp_valid = 1'b1; dresp_data = 32'h5555_5555;
        cyc("stray", 1'b1, 1'b0);
        issue(32'h500, 5'd5, 1'b1, 1'b0, LS_WORD, 1'b0, 2'd0, 32'd55, 32'd55);
        cyc("stray_acc", 1'b1, 1'b0);
        idle();
        cyc("stray_commit", 1'b1, 1'b1);
        dresp_valid = 1'b0;

        issue(32'h600, 5'd6, 1'b1, 1'b1, LS_WORD, 1'b0, 2'd0, 32'h0, 32'h0);
        cyc("rw_acc", 1'b1, 1'b0);
        idle();
        wait_chk("rw_w1", 5'd6);
        resetn = 1'b0;
        q.delete();
        #1;
        chk("rw_rst.m_ready", {31'd0, m_ready}, 32'd1);
        chk("rw_rst.fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("rw_rst.commit_pc", commit_pc, 32'hbfc0_0000);
        @(negedge clk);
        resetn = 1'b1;
        dresp_valid = 1'b1; dresp_data = 32'h1234_abcd;
        cyc("rw_stale", 1'b1, 1'b0);
        dresp_valid = 1'b0;
        cyc("rw_after", 1'b1, 1'b0);
        chk("rw_after.commit_pc", commit_pc, 32'hbfc0_0000);

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
